fifo_mac_sequencer: RTL and testbench

- Consumer stage directly downstream of the activation/weight register FIFOs in the neural processor datapath.
- On start, walks a shared read select over all 2**ADDR_WIDTH entries of an activation FIFO and a weight FIFO, and multiply-accumulates the signed pairs.
- Requantizes the result (shift, optional ReLU, saturate to DATA_WIDTH) and presents it on a valid/ready handshake, sized to feed the next layer's FIFO value_in.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/requant_sat.sv | 46 ++++
 rtl/fifo_mac_sequencer.sv | 156 +++++++++++++++
 tb/tb_fifo_mac_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural processor datapath: sequencer state
// encoding, accumulator width derivation and signed saturation bounds.
package nn_pkg;

    // Dot-product sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Exact accumulator width: a full-width product plus one bit per doubling
    // of the term count, so a sum of 2**aw products can never overflow.
    function automatic int acc_width(input int dw, input int aw);
        return 2 * dw + aw;
    endfunction

    // Largest value representable in a dw-bit two's complement word.
    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Smallest value representable in a dw-bit two's complement word.
    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: arithmetic right shift, optional ReLU, then saturation of a
// wide signed accumulator down to the narrow activation width. Purely
// combinational; the parent registers the result.
module requant_sat
    import nn_pkg::*;
#(
    parameter int ACC_WIDTH   = 19,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    input  logic                          relu_en_i,
    output logic signed [DATA_WIDTH-1:0] q_o
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] shifted_d;
    logic signed [ACC_WIDTH-1:0] relu_d;

    // Shift (floor), rectify, then clamp into the output range.
    always_comb begin
        // Shifting by the full width or more leaves only the sign: 0 or -1.
        if (int'(shift_i) >= ACC_WIDTH) begin
            shifted_d = {ACC_WIDTH{acc_i[ACC_WIDTH-1]}};
        end else begin
            shifted_d = acc_i >>> shift_i;
        end

        relu_d = shifted_d;
        if (relu_en_i && shifted_d[ACC_WIDTH-1]) begin
            relu_d = '0;
        end

        if (relu_d > SAT_MAX) begin
            q_o = SAT_MAX[DATA_WIDTH-1:0];
        end else if (relu_d < SAT_MIN) begin
            q_o = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            q_o = relu_d[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fifo_mac_sequencer.sv
// Dot-product sequencer sitting behind the activation and weight register
// FIFOs. On start it walks a shared read select over every FIFO entry,
// multiply-accumulates the signed pairs through a one-stage product register,
// requantizes the sum and offers it on a valid/ready handshake.
module fifo_mac_sequencer
    import nn_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, ADDR_WIDTH),
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          start,
    output logic        [ADDR_WIDTH-1:0]  rd_sel,
    input  logic signed [DATA_WIDTH-1:0]  act_in,
    input  logic signed [DATA_WIDTH-1:0]  wgt_in,
    input  logic                          fifo_load_enable,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          relu_en,
    output logic                          busy,
    output logic signed [ACC_WIDTH-1:0]   result_acc,
    output logic signed [DATA_WIDTH-1:0]  result_q,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          err_hazard
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    // Sequencer state and datapath registers.
    state_t                        state_q;
    logic        [ADDR_WIDTH-1:0]  idx_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [PROD_WIDTH-1:0]  prod_q;
    logic                          prod_vld_q;
    logic        [SHIFT_WIDTH-1:0] shift_q;
    logic                          relu_q;
    logic                          busy_q;
    logic                          result_valid_q;
    logic                          err_hazard_q;
    logic signed [ACC_WIDTH-1:0]   result_acc_q;
    logic signed [DATA_WIDTH-1:0]  result_q_q;

    // Next-value datapath terms.
    logic signed [PROD_WIDTH-1:0]  act_ext_d;
    logic signed [PROD_WIDTH-1:0]  wgt_ext_d;
    logic signed [PROD_WIDTH-1:0]  prod_d;
    logic signed [ACC_WIDTH-1:0]   prod_ext_d;
    logic signed [ACC_WIDTH-1:0]   final_sum_d;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [DATA_WIDTH-1:0]  requant_d;

    // Product of the current FIFO pair and the running sum including the
    // product captured on the previous edge.
    always_comb begin
        act_ext_d   = {{DATA_WIDTH{act_in[DATA_WIDTH-1]}}, act_in};
        wgt_ext_d   = {{DATA_WIDTH{wgt_in[DATA_WIDTH-1]}}, wgt_in};
        // The low PROD_WIDTH bits hold the exact signed product.
        prod_d      = act_ext_d * wgt_ext_d;
        prod_ext_d  = {{(ACC_WIDTH - PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
        final_sum_d = acc_q + prod_ext_d;
        acc_d       = prod_vld_q ? final_sum_d : acc_q;
    end

    // Requantization of the completed sum; captured into result_q at DRAIN.
    requant_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc_i     (final_sum_d),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .q_o       (requant_d)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            prod_q         <= '0;
            prod_vld_q     <= 1'b0;
            shift_q        <= '0;
            relu_q         <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            err_hazard_q   <= 1'b0;
            result_acc_q   <= '0;
            result_q_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_RUN;
                        idx_q        <= '0;
                        acc_q        <= '0;
                        prod_vld_q   <= 1'b0;
                        shift_q      <= shift;
                        relu_q       <= relu_en;
                        err_hazard_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_RUN: begin
                    prod_q     <= prod_d;
                    prod_vld_q <= 1'b1;
                    acc_q      <= acc_d;
                    // Wraps back to zero on the last term so rd_sel idles at 0.
                    idx_q      <= idx_q + IDX_ONE;
                    if (fifo_load_enable) begin
                        err_hazard_q <= 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    acc_q          <= final_sum_d;
                    prod_vld_q     <= 1'b0;
                    result_acc_q   <= final_sum_d;
                    result_q_q     <= requant_d;
                    result_valid_q <= 1'b1;
                    state_q        <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_sel       = idx_q;
    assign busy         = busy_q;
    assign result_acc   = result_acc_q;
    assign result_q     = result_q_q;
    assign result_valid = result_valid_q;
    assign err_hazard   = err_hazard_q;

endmodule

// File: tb/tb_fifo_mac_sequencer.sv
// Testbench for fifo_mac_sequencer: models the two FIFOs as arrays indexed
// by rd_sel, predicts each dot product with plain arithmetic and checks the
// DUT through a scoreboard popped by an independent handshake monitor.
module tb_fifo_mac_sequencer;

    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int N    = 1 << AW;
    localparam int ACCW = 2 * DW + AW;
    localparam int SW   = 5;

    logic                   clk = 1'b0;
    logic                   rstb;
    logic                   start;
    logic [AW-1:0]          rd_sel;
    logic signed [DW-1:0]   act_in;
    logic signed [DW-1:0]   wgt_in;
    logic                   fifo_load_enable;
    logic [SW-1:0]          shift;
    logic                   relu_en;
    logic                   busy;
    logic signed [ACCW-1:0] result_acc;
    logic signed [DW-1:0]   result_q;
    logic                   result_valid;
    logic                   result_ready;
    logic                   err_hazard;

    logic signed [DW-1:0]   act_mem [N];
    logic signed [DW-1:0]   wgt_mem [N];

    typedef struct {
        longint acc;
        longint q;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    int     result_no = 0;
    int     rd_trace [16];
    logic   busy_after_start;
    logic   haz_after_start;

    always #5 clk = ~clk;

    // Combinational FIFO read ports.
    assign act_in = act_mem[rd_sel];
    assign wgt_in = wgt_mem[rd_sel];

    fifo_mac_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (ACCW),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .rstb             (rstb),
        .start            (start),
        .rd_sel           (rd_sel),
        .act_in           (act_in),
        .wgt_in           (wgt_in),
        .fifo_load_enable (fifo_load_enable),
        .shift            (shift),
        .relu_en          (relu_en),
        .busy             (busy),
        .result_acc       (result_acc),
        .result_q         (result_q),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .err_hazard       (err_hazard)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: exact dot product, floor division by 2**sh, ReLU, clamp.
    function automatic exp_t model(input int sh, input bit relu);
        exp_t   e;
        longint sum;
        longint div;
        longint s;
        sum = 0;
        for (int k = 0; k < N; k++) begin
            sum += longint'(act_mem[k]) * longint'(wgt_mem[k]);
        end
        div = longint'(1) << sh;
        s   = sum / div;
        if ((sum % div != 0) && (sum < 0)) s = s - 1;
        if (relu && (s < 0)) s = 0;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        e.acc = sum;
        e.q   = s;
        return e;
    endfunction

    // Monitor: each accepted result is compared with the oldest prediction.
    always @(negedge clk) begin
        if (!rstb && result_valid && result_ready) begin
            result_no++;
            $display("result %0d: acc=%0d q=%0d hazard=%0b", result_no, result_acc, result_q, err_hazard);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL scoreboard: unexpected result acc=%0d q=%0d, none expected", result_acc, result_q);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_acc", longint'(result_acc), mon_e.acc);
                check("result_q", longint'(result_q), mon_e.q);
            end
        end
    end

    task automatic load_ramp(input int wgt);
        for (int k = 0; k < N; k++) begin
            act_mem[k] = DW'(k);
            wgt_mem[k] = DW'(wgt);
        end
    endtask

    task automatic load_const(input int a, input int w);
        for (int k = 0; k < N; k++) begin
            act_mem[k] = DW'(a);
            wgt_mem[k] = DW'(w);
        end
    endtask

    // Issue one dot product and wait for result_valid. Optionally pulses
    // fifo_load_enable at the RUN edge with idx=haz_idx, or asserts reset
    // while idx=rst_idx (lat=-2 then). Returns at posedge+1 of the valid edge.
    task automatic start_dot(input int sh, input bit relu, input bit use_exp,
                             input longint eacc, input longint eq,
                             input int haz_idx, input int rst_idx, output int lat);
        exp_t e;
        bit   injected;
        injected     = 1'b0;
        result_ready = 1'b0;
        shift        = SW'(sh);
        relu_en      = relu;
        if (use_exp) begin
            e.acc = eacc;
            e.q   = eq;
        end else begin
            e = model(sh, relu);
        end
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start            = 1'b0;
        busy_after_start = busy;
        haz_after_start  = err_hazard;
        rd_trace[0]      = int'(rd_sel);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (haz_idx >= 0 && !injected && int'(rd_sel) == haz_idx) begin
                fifo_load_enable = 1'b1;
                injected         = 1'b1;
            end
            if (rst_idx >= 0 && int'(rd_sel) == rst_idx) begin
                rstb = 1'b1;
                #1;
                check("reset_abort_valid", longint'(result_valid), 0);
                check("reset_abort_busy", longint'(busy), 0);
                check("reset_abort_rd_sel", longint'(rd_sel), 0);
                check("reset_abort_acc", longint'(result_acc), 0);
                check("reset_abort_q", longint'(result_q), 0);
                check("reset_abort_hazard", longint'(err_hazard), 0);
                void'(exp_q.pop_back());
                @(negedge clk);
                rstb = 1'b0;
                lat  = -2;
                break;
            end
            @(posedge clk);
            #1;
            fifo_load_enable = 1'b0;
            if (c < 16) rd_trace[c] = int'(rd_sel);
            if (result_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == -1) begin
            total_cnt++;
            $display("FAIL valid_timeout: result_valid not seen within 40 cycles, required within 9");
            exp_q.delete();
            rstb = 1'b1;
            @(negedge clk);
            rstb = 1'b0;
        end
    endtask

    // Keep ready low for hold cycles, then accept and confirm return to IDLE.
    task automatic accept_result(input int hold);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("valid_after_accept", longint'(result_valid), 0);
        check("busy_after_accept", longint'(busy), 0);
    endtask

    initial begin
        int lat;
        int bad;
        int sh;
        bit relu;

        rstb             = 1'b1;
        start            = 1'b0;
        fifo_load_enable = 1'b0;
        shift            = '0;
        relu_en          = 1'b0;
        result_ready     = 1'b0;
        load_const(0, 0);
        #1;
        check("reset_rd_sel", longint'(rd_sel), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(result_valid), 0);
        check("reset_acc", longint'(result_acc), 0);
        check("reset_q", longint'(result_q), 0);
        check("reset_hazard", longint'(err_hazard), 0);
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);

        // Ramp times ones: sum 0..7 = 28, rd_sel walk and latency.
        load_ramp(1);
        start_dot(0, 1'b0, 1'b1, 28, 28, -1, -1, lat);
        check("latency", lat, 9);
        check("busy_after_start", longint'(busy_after_start), 1);
        bad = 0;
        for (int c = 0; c < N; c++) if (rd_trace[c] != c) bad++;
        if (rd_trace[N] != 0) bad++;
        check("rd_sel_walk_errors", bad, 0);
        accept_result(0);

        // Full-scale negative pairs: 8 * 16384 = 131072.
        load_const(-128, -128);
        start_dot(0, 1'b0, 1'b1, 131072, 127, -1, -1, lat);
        accept_result(1);
        start_dot(10, 1'b0, 1'b1, 131072, 127, -1, -1, lat);
        accept_result(0);
        start_dot(11, 1'b0, 1'b1, 131072, 64, -1, -1, lat);
        accept_result(2);
        start_dot(31, 1'b0, 1'b1, 131072, 0, -1, -1, lat);
        accept_result(0);

        // Negative ramp: -28, floor shift and ReLU.
        load_ramp(-1);
        start_dot(2, 1'b0, 1'b1, -28, -7, -1, -1, lat);
        accept_result(0);
        start_dot(2, 1'b1, 1'b1, -28, 0, -1, -1, lat);
        accept_result(0);
        start_dot(19, 1'b0, 1'b1, -28, -1, -1, -1, lat);
        accept_result(0);
        start_dot(31, 1'b1, 1'b1, -28, 0, -1, -1, lat);
        accept_result(0);

        // Backpressure: outputs stable while ready is low, start ignored,
        // including on the accept edge itself.
        load_ramp(1);
        start_dot(0, 1'b0, 1'b1, 28, 28, -1, -1, lat);
        bad = 0;
        for (int h = 0; h < 5; h++) begin
            start = (h % 2 == 0);
            @(posedge clk);
            #1;
            if (!result_valid || !busy || result_acc != 28 || result_q != 28 || rd_sel != 0) bad++;
        end
        check("hold_unstable_cycles", bad, 0);
        start        = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        result_ready = 1'b0;
        check("valid_after_accept_with_start", longint'(result_valid), 0);
        check("busy_after_accept_with_start", longint'(busy), 0);
        check("acc_retained_after_accept", longint'(result_acc), 28);
        @(posedge clk);
        #1;
        check("no_start_from_accept_cycle", longint'(busy), 0);

        // Hazard: load during RUN idx=3 flags and survives until next start.
        start_dot(0, 1'b0, 1'b1, 28, 28, 3, -1, lat);
        check("hazard_at_valid", longint'(err_hazard), 1);
        accept_result(0);
        check("hazard_after_accept", longint'(err_hazard), 1);
        start_dot(0, 1'b0, 1'b1, 28, 28, -1, -1, lat);
        check("hazard_cleared_by_start", longint'(haz_after_start), 0);
        accept_result(0);

        // Reset mid-RUN aborts; a fresh start still computes correctly.
        start_dot(0, 1'b0, 1'b1, 28, 28, -1, 4, lat);
        check("reset_aborted_run", lat, -2);
        start_dot(0, 1'b0, 1'b1, 28, 28, -1, -1, lat);
        check("latency_after_reset", lat, 9);
        accept_result(0);

        // Randomized data, shift, ReLU and backpressure.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < N; k++) begin
                act_mem[k] = DW'($urandom_range(0, 255));
                wgt_mem[k] = DW'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) sh = int'($urandom_range(0, 31));
            else                           sh = int'($urandom_range(0, 12));
            relu = 1'($urandom_range(0, 1));
            start_dot(sh, relu, 1'b0, 0, 0, -1, -1, lat);
            check("random_latency", lat, 9);
            accept_result(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
